// File: rtl/bus_map_pkg.sv
// Shared bus map for the 6502 memory responder: FSM states, region
// decode constants and the open-bus default.
package bus_map_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    SEL_OPEN,
    SEL_RAM,
    SEL_ROM
  } region_t;

  localparam int unsigned RAM_AW_DEF   = 11;
  localparam logic [15:0] RAM_TOP      = 16'h0800;
  localparam logic [15:0] ROM_BASE_DEF = 16'h8000;
  localparam int unsigned ROM_AW       = 15;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  localparam logic [7:0] OPEN_BUS_DEF = 8'hFF;

  // RAM wins over ROM if a parameter choice ever makes the two overlap.
  function automatic region_t decode_region(input logic [15:0] addr,
                                            input int unsigned ram_aw,
                                            input logic [15:0] rom_base);
    if (32'(addr) < (32'd1 << ram_aw)) return SEL_RAM;
    else if (addr >= rom_base)         return SEL_ROM;
    else                               return SEL_OPEN;
  endfunction

endpackage

// File: rtl/bus_sram.sv
// Single-clock synchronous RAM, one read port and one write port.
// Read-first: a same-address read and write in one cycle returns old data.
module bus_sram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [2**AW];

  // Registered read of the pre-write contents, then optional write.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 6502 core bus: RAM/ROM/open-bus decode,
// 1-cycle read latency, byte-stream ROM loader and core reset sequencing.
module mem_responder
  import bus_map_pkg::*;
#(
  parameter int unsigned RAM_AW   = RAM_AW_DEF,
  parameter logic [15:0] ROM_BASE = ROM_BASE_DEF,
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEF,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wr_data,
  input  logic        wr_enable,
  output logic [7:0]  rd_data,
  output logic        cpu_resetn,
  input  logic        ld_start,
  input  logic [14:0] ld_base,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic [15:0] ld_count,
  output logic        ld_wrap,
  output logic        rom_wr_err
);

  localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

  state_t              state_q, state_d;
  region_t             region, sel_q;
  logic                load_init;
  logic                accept;
  logic [ROM_AW-1:0]   offset;
  logic [3:0]          hold_cnt;
  logic [7:0]          ram_q, rom_q;
  logic [RAM_AW-1:0]   ram_addr;
  logic [ROM_AW-1:0]   rom_addr;
  logic                ram_we;

  assign region   = decode_region(address, RAM_AW, ROM_BASE);
  assign ram_addr = address[RAM_AW-1:0];
  assign rom_addr = ROM_AW'(address - ROM_BASE);
  assign ram_we   = cpu_resetn && wr_enable && (region == SEL_RAM);
  assign accept   = ld_ready && ld_valid;

  bus_sram #(.AW(RAM_AW), .DW(8)) u_ram (
    .clk     (clk),
    .rd_addr (ram_addr),
    .rd_data (ram_q),
    .wr_en   (ram_we),
    .wr_addr (ram_addr),
    .wr_data (wr_data)
  );

  bus_sram #(.AW(ROM_AW), .DW(8)) u_rom (
    .clk     (clk),
    .rd_addr (rom_addr),
    .rd_data (rom_q),
    .wr_en   (accept),
    .wr_addr (offset),
    .wr_data (ld_data)
  );

  // Remember which region the sampled address hit so the output mux lines
  // up with the memories' registered read data.
  always_ff @(posedge clk) begin
    if (reset) sel_q <= SEL_OPEN;
    else       sel_q <= region;
  end

  // Output mux over the registered read sources.
  always_comb begin
    rd_data = OPEN_BUS;
    unique case (sel_q)
      SEL_RAM: rd_data = ram_q;
      SEL_ROM: rd_data = rom_q;
      default: rd_data = OPEN_BUS;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    ld_ready   = 1'b0;
    cpu_resetn = 1'b0;
    load_init  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d   = LOAD;
          load_init = 1'b1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_last) state_d = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        cpu_resetn = 1'b1;
        if (ld_start) begin
          state_d   = LOAD;
          load_init = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader offset, byte count (saturating) and sticky wrap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset   <= '0;
      ld_count <= '0;
      ld_wrap  <= 1'b0;
    end else if (load_init) begin
      offset   <= ld_base;
      ld_count <= '0;
      ld_wrap  <= 1'b0;
    end else if (accept) begin
      offset <= offset + 1'b1;
      if (offset == '1)    ld_wrap  <= 1'b1;
      if (ld_count != '1)  ld_count <= ld_count + 1'b1;
    end
  end

  // Cycles spent in HOLD before the core is released.
  always_ff @(posedge clk) begin
    if (reset)                hold_cnt <= '0;
    else if (state_q == HOLD) hold_cnt <= hold_cnt + 1'b1;
    else                      hold_cnt <= '0;
  end

  // Flag a core write into ROM one cycle later.
  always_ff @(posedge clk) begin
    if (reset) rom_wr_err <= 1'b0;
    else       rom_wr_err <= cpu_resetn && wr_enable && (region == SEL_ROM);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: array-based behavioural model,
// per-cycle compare process, directed scenarios plus randomized traffic.
module tb_mem_responder;
  import bus_map_pkg::*;

  localparam int RST_HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;
  logic [7:0]  rd_data;
  logic        cpu_resetn;
  logic        ld_start;
  logic [14:0] ld_base;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [15:0] ld_count;
  logic        ld_wrap;
  logic        rom_wr_err;

  always #5 clk = ~clk;

  mem_responder #(
    .RAM_AW   (11),
    .ROM_BASE (16'h8000),
    .OPEN_BUS (8'hFF),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .wr_data    (wr_data),
    .wr_enable  (wr_enable),
    .rd_data    (rd_data),
    .cpu_resetn (cpu_resetn),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_count   (ld_count),
    .ld_wrap    (ld_wrap),
    .rom_wr_err (rom_wr_err)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] ram_m [2048];
  bit         ram_k [2048];
  logic [7:0] rom_m [32768];
  bit         rom_k [32768];

  bit          m_valid = 0;
  logic [7:0]  m_rd;
  bit          m_rd_k;
  bit          m_load, m_run, m_err, m_wrap;
  int          m_hold;
  int          m_off;
  int          m_cnt;

  always @(posedge clk) begin
    int a;
    a = int'(address);
    if (reset) begin
      m_valid = 1;
      m_rd = 8'hFF; m_rd_k = 1;
      m_load = 0; m_run = 0; m_hold = 0; m_err = 0;
      m_cnt = 0; m_wrap = 0;
    end else if (m_valid) begin
      // read sees memory before any write of this cycle
      if (a < 2048)        begin m_rd = ram_m[a];         m_rd_k = ram_k[a]; end
      else if (a >= 32768) begin m_rd = rom_m[a - 32768]; m_rd_k = rom_k[a - 32768]; end
      else                 begin m_rd = 8'hFF;            m_rd_k = 1; end
      m_err = m_run && wr_enable && (a >= 32768);
      if (m_run && wr_enable && a < 2048) begin
        ram_m[a] = wr_data; ram_k[a] = 1;
      end
      if (m_load) begin
        if (ld_valid) begin
          rom_m[m_off] = ld_data; rom_k[m_off] = 1;
          if (m_off == 32767) m_wrap = 1;
          m_off = (m_off + 1) % 32768;
          if (m_cnt < 65535) m_cnt++;
          if (ld_last) begin m_load = 0; m_hold = RST_HOLD; end
        end
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_run = 1;
      end else if (ld_start) begin
        m_load = 1; m_run = 0;
        m_off = int'(ld_base); m_cnt = 0; m_wrap = 0;
      end
    end
  end

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cpu_resetn", cpu_resetn, m_run);
      chk("ld_ready",   ld_ready,   m_load);
      chk("ld_count",   ld_count,   m_cnt);
      chk("ld_wrap",    ld_wrap,    m_wrap);
      chk("rom_wr_err", rom_wr_err, m_err);
      if (m_rd_k) chk("rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [14:0] base, input logic [7:0] bytes[$], input bit rnd);
    ld_start = 1; ld_base = base;
    tick();
    ld_start = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      while (rnd && $urandom_range(0, 3) == 0) begin
        ld_valid  = 0;
        address   = 16'($urandom);
        wr_enable = 1'($urandom);
        wr_data   = 8'($urandom);
        ld_start  = 1'($urandom);
        ld_base   = 15'($urandom);
        tick();
        ld_start  = 0;
      end
      ld_valid = 1; ld_data = bytes[i]; ld_last = (i == bytes.size() - 1);
      tick();
    end
    ld_valid = 0; ld_last = 0; wr_enable = 0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 30 && !cpu_resetn; i++) tick();
    chk("run_timeout", cpu_resetn, 1);
  endtask

  task automatic rd_lit(input logic [15:0] addr, input logic [7:0] exp, input string name);
    address = addr; wr_enable = 0;
    tick();
    chk(name, rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [15:0] ra;
    int r, n;

    reset = 1; address = 16'h4000; wr_data = 0; wr_enable = 0;
    ld_start = 0; ld_base = 0; ld_valid = 0; ld_data = 0; ld_last = 0;

    // 1. reset, then idle
    repeat (3) tick();
    chk("rst_resetn", cpu_resetn, 0);
    chk("rst_ready",  ld_ready,   0);
    chk("rst_rd",     rd_data,    8'hFF);
    chk("rst_count",  ld_count,   0);
    reset = 0;
    rd_lit(16'h0800, 8'hFF, "idle_open_0800");
    rd_lit(16'h4000, 8'hFF, "idle_open_4000");
    rd_lit(16'h7FFF, 8'hFF, "idle_open_7fff");
    chk("idle_resetn", cpu_resetn, 0);

    // 2. reset vector load
    q = '{8'h00, 8'h80};
    load(15'h7FFC, q, 0);
    chk("vec_count", ld_count, 2);
    for (int i = 1; i <= RST_HOLD; i++) begin
      tick();
      chk("hold_resetn", cpu_resetn, (i == RST_HOLD));
    end
    rd_lit(VEC_RESET,         8'h00, "vec_lo");
    rd_lit(VEC_RESET + 16'd1, 8'h80, "vec_hi");

    // 3. program at ROM base
    q = '{8'hA9, 8'h00, 8'h8D, 8'h00, 8'h02};
    load(15'h0000, q, 0);
    wait_run();
    for (int i = 0; i < 5; i++) rd_lit(16'h8000 + 16'(i), q[i], "prog_byte");
    rd_lit(16'h4000, 8'hFF, "prog_open");

    // 4. core RAM write and ROM write attempt
    address = 16'h0200; wr_data = 8'h55; wr_enable = 1;
    tick();
    wr_enable = 0;
    rd_lit(16'h0200, 8'h55, "ram_rw");
    address = 16'h8000; wr_data = 8'h77; wr_enable = 1;
    tick();
    wr_enable = 0;
    chk("rom_err_pulse", rom_wr_err, 1);
    tick();
    chk("rom_err_clear", rom_wr_err, 0);
    rd_lit(16'h8000, 8'hA9, "rom_kept");

    // 5. wrapping load
    q = '{8'h11, 8'h22, 8'h33};
    load(15'h7FFF, q, 0);
    chk("wrap_flag",  ld_wrap,  1);
    chk("wrap_count", ld_count, 3);
    wait_run();
    rd_lit(16'hFFFF, 8'h11, "wrap_b0");
    rd_lit(16'h8000, 8'h22, "wrap_b1");
    rd_lit(16'h8001, 8'h33, "wrap_b2");

    // 6. reload from RUN, reset mid-load
    ld_start = 1; ld_base = 15'h1234;
    tick();
    ld_start = 0;
    chk("mid_resetn_fall", cpu_resetn, 0);
    ld_valid = 1; ld_data = 8'h5A; tick();
    ld_data = 8'hC3; tick();
    ld_valid = 0;
    reset = 1; tick(); tick(); reset = 0;
    chk("abort_ready", ld_ready, 0);
    tick();
    chk("abort_idle_ready", ld_ready, 0);
    chk("abort_idle_resetn", cpu_resetn, 0);
    q = '{8'h01};
    load(15'h0010, q, 0);
    wait_run();
    rd_lit(16'h9234, 8'h5A, "abort_b0");
    rd_lit(16'h9235, 8'hC3, "abort_b1");

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        q.delete();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        ld_base = ($urandom_range(0, 3) == 0) ? 15'(32768 - $urandom_range(1, 4))
                                              : 15'($urandom);
        load(ld_base, q, 1);
        wait_run();
      end else begin
        case ($urandom_range(0, 3))
          0, 1:    ra = 16'($urandom_range(0, 2047));
          2:       ra = 16'h8000 | 16'($urandom_range(0, 32767));
          default: ra = 16'($urandom);
        endcase
        address   = ra;
        wr_data   = 8'($urandom);
        wr_enable = (r <= 4);
        tick();
        wr_enable = 0;
      end
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
